// File: rtl/lockout_pkg.sv
// lockout_pkg: shared types and constants for the lockout controller.
//   - state_t       : controller states
//   - STAT_*        : one-hot status_out codes, one per state
//   - VF_ST_*       : verifier status codes plus decode helpers, so the
//                     verifier status -> vf_done/vf_error mapping lives here
//   - SW_W          : width of the board switch bus
package lockout_pkg;

    localparam int SW_W = 10;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ARMED,
        ST_OPEN,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] STAT_CLEAR  = 4'b1000;
    localparam logic [3:0] STAT_ARMED  = 4'b0001;
    localparam logic [3:0] STAT_OPEN   = 4'b0010;
    localparam logic [3:0] STAT_LOCKED = 4'b0100;

    // Verifier-side status codes (its own one-hot status_out).
    localparam logic [3:0] VF_ST_IDLE  = 4'b0001;
    localparam logic [3:0] VF_ST_ENTRY = 4'b0010;
    localparam logic [3:0] VF_ST_DONE  = 4'b0100;
    localparam logic [3:0] VF_ST_ERROR = 4'b1000;

    function automatic logic vf_is_done(input logic [3:0] vf_status);
        return vf_status == VF_ST_DONE;
    endfunction

    function automatic logic vf_is_error(input logic [3:0] vf_status);
        return vf_status == VF_ST_ERROR;
    endfunction

endpackage

// File: rtl/lockout_ctrl_if.sv
// lockout_ctrl_if: link between the lockout controller and the verifier.
//   vf_sw    : gated switches toward the verifier
//   vf_clear : synchronous return-to-idle for the verifier
//   vf_en    : verifier input enable
//   vf_done  : verifier reached its done state (level)
//   vf_error : verifier reached its error state (level)
// modport master = controller side, slave = verifier side.
interface lockout_ctrl_if;
    import lockout_pkg::*;

    logic [SW_W-1:0] vf_sw;
    logic            vf_clear;
    logic            vf_en;
    logic            vf_done;
    logic            vf_error;

    modport master (
        output vf_sw, vf_clear, vf_en,
        input  vf_done, vf_error
    );

    modport slave (
        input  vf_sw, vf_clear, vf_en,
        output vf_done, vf_error
    );
endinterface

// File: rtl/lockout_ctrl_down_timer.sv
// down_timer: loadable countdown shared by the OPEN and LOCKED states.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load load_val (wins over en)
//   load_val : value to load
//   en       : decrement by one, stopping at zero
//   zero     : count is zero
module down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/lockout_ctrl.sv
// lockout_ctrl: sequences a password verifier. Restarts it after every
// attempt, counts consecutive failures, locks it out for LOCK_CYCLES after
// MAX_FAILS failures, and holds `unlocked` for OPEN_CYCLES after a success.
//   clk, rst   : clock, asynchronous active-high reset
//   sw_in      : raw board switches
//   relock     : early exit from OPEN
//   vf         : verifier link (gated switches, clear, enable, done/error)
//   unlocked   : access granted (OPEN)
//   locked     : lockout active (LOCKED)
//   fail_cnt   : consecutive failures so far
//   status_out : one-hot state code
module lockout_ctrl
    import lockout_pkg::*;
#(
    parameter int MAX_FAILS   = 3,
    parameter int OPEN_CYCLES = 100,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SW_W-1:0]                sw_in,
    input  logic                           relock,
    lockout_ctrl_if.master                 vf,
    output logic                           unlocked,
    output logic                           locked,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic [3:0]                     status_out
);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FCNT_W  = $clog2(MAX_FAILS + 1);

    localparam logic [FCNT_W-1:0] FAIL_LIMIT = FCNT_W'(MAX_FAILS);

    state_t            state, state_nxt;
    logic [FCNT_W-1:0] fail_nxt;
    logic [FCNT_W-1:0] fail_inc;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_zero;

    down_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            fail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
        end
    end

    // Saturating increment; the counter never wraps past MAX_FAILS.
    assign fail_inc = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + FCNT_W'(1);

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                // error takes precedence over done
                if (vf.vf_error) begin
                    fail_nxt = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_nxt = ST_LOCKED;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_nxt = ST_CLEAR;
                    end
                end else if (vf.vf_done) begin
                    fail_nxt  = '0;
                    state_nxt = ST_OPEN;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(OPEN_CYCLES - 1);
                end
            end
            ST_OPEN: begin
                tmr_en = 1'b1;
                if (tmr_zero || relock) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_LOCKED: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    fail_nxt  = '0;
                    state_nxt = ST_CLEAR;
                end
            end
        endcase
    end

    always_comb begin
        status_out = STAT_CLEAR;
        unique case (state)
            ST_CLEAR:  status_out = STAT_CLEAR;
            ST_ARMED:  status_out = STAT_ARMED;
            ST_OPEN:   status_out = STAT_OPEN;
            ST_LOCKED: status_out = STAT_LOCKED;
        endcase
    end

    assign vf.vf_clear = (state == ST_CLEAR);
    assign vf.vf_en    = (state == ST_ARMED);
    assign vf.vf_sw    = vf.vf_en ? sw_in : '0;
    assign unlocked    = (state == ST_OPEN);
    assign locked      = (state == ST_LOCKED);
endmodule

// File: tb/tb_lockout_ctrl.sv
// tb_lockout_ctrl: randomized scoreboard bench for lockout_ctrl.
// Stimulus drives random verifier results, relock and switches at each
// falling edge, steps a cycles-remaining reference model and queues the
// expected post-edge outputs; a monitor pops and compares after each
// rising edge. Asynchronous resets are injected mid-OPEN.
module tb_lockout_ctrl;
    localparam int MAXF  = 3;
    localparam int OPENC = 4;
    localparam int LOCKC = 8;
    localparam int NCYC  = 2000;

    localparam int P_CLEAR  = 0;
    localparam int P_ARMED  = 1;
    localparam int P_OPEN   = 2;
    localparam int P_LOCKED = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       relock;
    logic [9:0] sw_in;
    logic       unlocked;
    logic       locked;
    logic [1:0] fail_cnt;
    logic [3:0] status_out;

    lockout_ctrl_if vif ();

    lockout_ctrl #(
        .MAX_FAILS   (MAXF),
        .OPEN_CYCLES (OPENC),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .relock     (relock),
        .vf         (vif),
        .unlocked   (unlocked),
        .locked     (locked),
        .fail_cnt   (fail_cnt),
        .status_out (status_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        int         fails;
        logic [9:0] sw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   started  = 1'b0;

    // reference model: phase, cycles left in the timed phase, failures
    int m_phase = P_CLEAR;
    int m_left  = 0;
    int m_fails = 0;
    int n_locks = 0;
    int n_opens = 0;
    int n_rsts  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    endtask

    function automatic int onehot(input int p);
        case (p)
            P_CLEAR:  return 4'b1000;
            P_ARMED:  return 4'b0001;
            P_OPEN:   return 4'b0010;
            default:  return 4'b0100;
        endcase
    endfunction

    task automatic check_outputs(input exp_t e);
        chk("status_out", int'(status_out),     onehot(e.phase));
        chk("vf_clear",   int'(vif.vf_clear),   int'(e.phase == P_CLEAR));
        chk("vf_en",      int'(vif.vf_en),      int'(e.phase == P_ARMED));
        chk("unlocked",   int'(unlocked),       int'(e.phase == P_OPEN));
        chk("locked",     int'(locked),         int'(e.phase == P_LOCKED));
        chk("fail_cnt",   int'(fail_cnt),       e.fails);
        chk("vf_sw",      int'(vif.vf_sw),      (e.phase == P_ARMED) ? int'(e.sw) : 0);
    endtask

    function automatic void model_step(input bit d, input bit e, input bit r);
        case (m_phase)
            P_CLEAR: m_phase = P_ARMED;
            P_ARMED: begin
                if (e) begin
                    if (m_fails < MAXF) m_fails++;
                    if (m_fails == MAXF) begin
                        m_phase = P_LOCKED;
                        m_left  = LOCKC;
                        n_locks++;
                    end else begin
                        m_phase = P_CLEAR;
                    end
                end else if (d) begin
                    m_fails = 0;
                    m_phase = P_OPEN;
                    m_left  = OPENC;
                    n_opens++;
                end
            end
            P_OPEN: begin
                m_left--;
                if (m_left == 0 || r) m_phase = P_CLEAR;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_fails = 0;
                    m_phase = P_CLEAR;
                end
            end
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.phase = m_phase;
        e.fails = m_fails;
        e.sw    = sw_in;
        q.push_back(e);
        started = 1'b1;
    endfunction

    // monitor
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            check_outputs(q.pop_front());
        end else if (started) begin
            n_checks++;
            $display("FAIL queue_underflow t=%0t got=empty exp=entry", $time);
        end
    end

    initial begin
        exp_t rs;
        bit   d, e, r;
        rst            = 1'b0;
        relock         = 1'b0;
        sw_in          = '0;
        vif.vf_done    = 1'b0;
        vif.vf_error   = 1'b0;
        #1 rst = 1'b1;
        #1;
        rs.phase = P_CLEAR; rs.fails = 0; rs.sw = '0;
        check_outputs(rs);

        // one cycle with reset still held
        @(negedge clk);
        sw_in = 10'h3FF;
        push_exp();

        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;

            if (m_phase == P_OPEN && n_rsts < 4 && $urandom_range(0, 7) == 0) begin
                #2 rst = 1'b1;
                #1;
                m_phase = P_CLEAR;
                m_fails = 0;
                n_rsts++;
                rs.phase = P_CLEAR; rs.fails = 0; rs.sw = sw_in;
                check_outputs(rs);
                push_exp();
                continue;
            end

            d = ($urandom_range(0, 99) < 25);
            e = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 12);
            vif.vf_done  = d;
            vif.vf_error = e;
            relock       = r;
            sw_in        = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            model_step(d, e, r);
            push_exp();
        end

        @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain t=%0t got=%0d exp=0", $time, q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
